dpu_pio_arbiter: RTL and testbench
==================================

DPU_PIO_ARBITER -- requirements
Module: dpu_pio_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default 24, PIO address width.
REQ-002 Parameter RSP_TIMEOUT, default 1024, read-response wait limit in cycles.
REQ-003 One clock; reset is asynchronous and active-low.
  - Ports: clk input 1, the clock; rst_n input 1, the reset.
REQ-004 Per master port, X=0 is the CPU/AXI-Lite PIO path and X=1 is the DMA path:
  - mX_cmd_valid input 1
  - mX_cmd_ready output 1
  - mX_cmd_type input 3
  - mX_cmd_addr input ADDR_BITS
  - mX_cmd_data input 8
  - mX_rsp_valid output 1
  - mX_rsp_data output 8
REQ-005 m1_lock input 1: DMA busy, keeps the grant with m1 between commands.
REQ-006 Downstream ports to dpu_top:
  - cmd_valid output 1
  - cmd_ready input 1
  - cmd_type output 3
  - cmd_addr output ADDR_BITS
  - cmd_data output 8
  - rsp_valid input 1
  - rsp_data input 8
REQ-007 Status ports:
  - grant output 1, the current owner.
  - busy output 1, state!=IDLE.
  - err_clr input 1, clears sticky flags.
  - stray_rsp output 1, sticky.
  - timeout_err output 1, sticky.

Function
REQ-010 FSM states and transitions:
  - IDLE -> ISSUE -> (WAIT_RSP if cmd_type==READ_BYTE(2), else HOLD).
  - WAIT_RSP -> HOLD -> IDLE.
REQ-011 IDLE, with any mX_cmd_valid high: select a master and register its type/addr/data into the cmd_* outputs.
  - grant is set to the selected master.
  - cmd_valid rises on the next cycle, giving 1-cycle latency.
REQ-012 Selection is round-robin: when both masters request, the one not granted last wins.
  - Exception: m1 wins whenever m1_lock=1 and m1 was granted last.
REQ-013 ISSUE: cmd_valid and cmd_* are held stable until cmd_ready=1.
  - In that cycle m<grant>_cmd_ready=1 (combinational from cmd_ready) for exactly one cycle.
  - cmd_valid deasserts on the next edge.
REQ-014 mX_cmd_ready is 0 in every other cycle and for the non-granted master.
REQ-015 WAIT_RSP: on rsp_valid=1, m<grant>_rsp_valid=1 and m<grant>_rsp_data=rsp_data in the same cycle, then go to HOLD.
REQ-016 HOLD lasts exactly one cycle, and mX_cmd_valid is ignored in it.
  - This absorbs requesters that keep cmd_valid high through the response cycle.
REQ-017 rsp_valid in any state other than WAIT_RSP is dropped and sets stray_rsp.
REQ-018 Simultaneous err_clr and a flag-setting event: the set wins.
REQ-019 mX_rsp_data is 0 when mX_rsp_valid=0.
REQ-020 cmd_type values pass through unmodified; only READ_BYTE(2) expects a response.

Reset
REQ-030 Asynchronous assertion forces the following, independent of clk:
  - state=IDLE, last grant=0, grant=0.
  - cmd_valid=0, cmd_type/addr/data=0.
  - mX_cmd_ready=0, mX_rsp_valid=0.
  - stray_rsp=0, timeout_err=0, timeout counter=0.
REQ-031 Reset mid-ISSUE or mid-WAIT_RSP abandons the transaction: no ready or response is delivered to any master.
REQ-032 The first command after deassertion is accepted no earlier than the first rising edge with rst_n=1.

Configuration
REQ-040 With DPU_PIO_ARB_TIMEOUT_EN defined:
  - A counter runs in WAIT_RSP.
  - After RSP_TIMEOUT cycles without rsp_valid, m<grant>_rsp_valid pulses with data 0x00, timeout_err sets, and the FSM goes to HOLD.
  - A late rsp_valid that arrives afterwards counts as stray.
REQ-041 Without DPU_PIO_ARB_TIMEOUT_EN:
  - No counter is present, WAIT_RSP waits indefinitely, and timeout_err is tied 0.

Structure
REQ-050 Shared package dpu_pkg holds:
  - CMD_WRITE_BYTE=0, CMD_READ_BYTE=2, CMD_WRITE_SCALE=5, CMD_WRITE_LAYER_DESC=6.
  - The PIO cmd struct typedef (type/addr/data).
  - The arbiter state enum.
REQ-051 Single module, no sub-modules; round-robin pointer and timeout counter inline.

Verification
REQ-060 Single write: m0 write_byte addr 0x000010 data 0xA5, cmd_ready held 1.
  - cmd_valid 1 cycle after request; m0_cmd_ready one pulse; back in IDLE 2 cycles later.
REQ-061 Read: m1 read_byte addr 0x000100, rsp_valid after 5 cycles with 0x3C.
  - m1_rsp_valid one pulse with 0x3C; m0_rsp_valid stays 0.
REQ-062 Contention: both request continuously, m1_lock=0.
  - Grants alternate 0,1,0,1.
  - With m1_lock=1, m1 is granted 4 consecutive times.
REQ-063 Stray response: rsp_valid while IDLE.
  - stray_rsp=1 and no mX_rsp_valid; err_clr clears it.
  - err_clr coincident with a new stray keeps stray_rsp=1.
REQ-064 Timeout (macro on, RSP_TIMEOUT=8): read with no response.
  - m0_rsp_valid with 0x00 at cycle 8 of WAIT_RSP and timeout_err=1.
  - With the macro off, busy stays 1.
REQ-065 Reset mid-WAIT_RSP: assert rst_n=0 between edges.
  - cmd_valid=0 and state=IDLE immediately; a following rsp_valid sets stray_rsp.

Source files
------------

// File: rtl/dpu_pkg.sv
// Shared DPU definitions: PIO command codes, the PIO command payload and the
// PIO arbiter state encoding.
package dpu_pkg;

    localparam int unsigned PIO_TYPE_W = 3;
    localparam int unsigned PIO_DATA_W = 8;
    // Address width carried in the stored command payload; the arbiter's
    // ADDR_BITS port width is cast to/from this.
    localparam int unsigned PIO_ADDR_W = 24;

    localparam logic [PIO_TYPE_W-1:0] CMD_WRITE_BYTE       = 3'd0;
    localparam logic [PIO_TYPE_W-1:0] CMD_READ_BYTE        = 3'd2;
    localparam logic [PIO_TYPE_W-1:0] CMD_WRITE_SCALE      = 3'd5;
    localparam logic [PIO_TYPE_W-1:0] CMD_WRITE_LAYER_DESC = 3'd6;

    typedef struct packed {
        logic [PIO_TYPE_W-1:0] cmd_type;
        logic [PIO_ADDR_W-1:0] addr;
        logic [PIO_DATA_W-1:0] data;
    } pio_cmd_t;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_ISSUE    = 2'd1,
        ARB_WAIT_RSP = 2'd2,
        ARB_HOLD     = 2'd3
    } arb_state_e;

endpackage

// File: rtl/dpu_pio_arbiter.sv
// Two-master PIO arbiter in front of dpu_top.
//   m0_*  : CPU/AXI-Lite PIO path      m1_* : DMA path (m1_lock keeps grant)
//   cmd_* / rsp_* : single downstream PIO channel to dpu_top
//   grant, busy, stray_rsp, timeout_err, err_clr : status / sticky flags
// Optional: define DPU_PIO_ARB_TIMEOUT_EN to bound the read-response wait to
// RSP_TIMEOUT cycles; otherwise WAIT_RSP waits forever and timeout_err is 0.
module dpu_pio_arbiter
    import dpu_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 24,
    parameter int unsigned RSP_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 m0_cmd_valid,
    output logic                 m0_cmd_ready,
    input  logic [2:0]           m0_cmd_type,
    input  logic [ADDR_BITS-1:0] m0_cmd_addr,
    input  logic [7:0]           m0_cmd_data,
    output logic                 m0_rsp_valid,
    output logic [7:0]           m0_rsp_data,

    input  logic                 m1_cmd_valid,
    output logic                 m1_cmd_ready,
    input  logic [2:0]           m1_cmd_type,
    input  logic [ADDR_BITS-1:0] m1_cmd_addr,
    input  logic [7:0]           m1_cmd_data,
    output logic                 m1_rsp_valid,
    output logic [7:0]           m1_rsp_data,
    input  logic                 m1_lock,

    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [2:0]           cmd_type,
    output logic [ADDR_BITS-1:0] cmd_addr,
    output logic [7:0]           cmd_data,
    input  logic                 rsp_valid,
    input  logic [7:0]           rsp_data,

    output logic                 grant,
    output logic                 busy,
    input  logic                 err_clr,
    output logic                 stray_rsp,
    output logic                 timeout_err
);

    localparam logic [1:0] ST_IDLE     = 2'(ARB_IDLE);
    localparam logic [1:0] ST_ISSUE    = 2'(ARB_ISSUE);
    localparam logic [1:0] ST_WAIT_RSP = 2'(ARB_WAIT_RSP);
    localparam logic [1:0] ST_HOLD     = 2'(ARB_HOLD);

    logic [1:0] state_q, state_d;
    logic       grant_q, grant_d;       // current owner, doubles as last-granted
    logic       cmd_valid_q, cmd_valid_d;
    pio_cmd_t   cmd_q, cmd_d;
    logic       busy_q;
    logic       stray_q, stray_d;

    logic       m0_eligible;
    logic       any_req;
    logic       sel;
    logic       tmo_hit;
    logic       rsp_fire;
    logic [7:0] rsp_payload;

`ifdef DPU_PIO_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(RSP_TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_err_q, tmo_err_d;
`endif

    // Request selection: while the DMA holds the lock and owned the last
    // command, the CPU path is masked so the grant stays with m1.
    always_comb begin
        m0_eligible = m0_cmd_valid && !(m1_lock && grant_q);
        any_req     = m0_eligible || m1_cmd_valid;
        sel         = (m0_eligible && m1_cmd_valid) ? !grant_q : m1_cmd_valid;
    end

    // Response path: a real response or a synthesized timeout response.
`ifdef DPU_PIO_ARB_TIMEOUT_EN
    assign tmo_hit = (state_q == ST_WAIT_RSP) && !rsp_valid &&
                     (cnt_q == CNT_W'(RSP_TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        rsp_fire    = (state_q == ST_WAIT_RSP) && (rsp_valid || tmo_hit);
        rsp_payload = rsp_valid ? rsp_data : 8'h00;
    end

    // Next-state and flag logic.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        cmd_valid_d = cmd_valid_q;
        cmd_d       = cmd_q;
        stray_d     = stray_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d     = ST_ISSUE;
                    grant_d     = sel;
                    cmd_valid_d = 1'b1;
                    if (sel) begin
                        cmd_d.cmd_type = m1_cmd_type;
                        cmd_d.addr     = PIO_ADDR_W'(m1_cmd_addr);
                        cmd_d.data     = m1_cmd_data;
                    end else begin
                        cmd_d.cmd_type = m0_cmd_type;
                        cmd_d.addr     = PIO_ADDR_W'(m0_cmd_addr);
                        cmd_d.data     = m0_cmd_data;
                    end
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = (cmd_q.cmd_type == CMD_READ_BYTE) ? ST_WAIT_RSP : ST_HOLD;
                end
            end
            ST_WAIT_RSP: begin
                if (rsp_fire) begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                // HOLD: one dead cycle so a requester still showing cmd_valid
                // from the previous command is not re-accepted.
                state_d = ST_IDLE;
            end
        endcase

        // Sticky flag: a set in the same cycle as err_clr wins.
        if (rsp_valid && (state_q != ST_WAIT_RSP)) begin
            stray_d = 1'b1;
        end else if (err_clr) begin
            stray_d = 1'b0;
        end
    end

`ifdef DPU_PIO_ARB_TIMEOUT_EN
    // Response wait counter, cleared whenever the FSM is outside WAIT_RSP.
    always_comb begin
        cnt_d     = (state_q == ST_WAIT_RSP) ? cnt_q + CNT_W'(1) : '0;
        tmo_err_d = tmo_err_q;
        if (tmo_hit) begin
            tmo_err_d = 1'b1;
        end else if (err_clr) begin
            tmo_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_q       <= '0;
            busy_q      <= 1'b0;
            stray_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            busy_q      <= (state_d != ST_IDLE);
            stray_q     <= stray_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_type  = cmd_q.cmd_type;
    assign cmd_addr  = ADDR_BITS'(cmd_q.addr);
    assign cmd_data  = cmd_q.data;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign stray_rsp = stray_q;

    // Handshake and response steering follow the downstream channel in the
    // same cycle; they are qualified by state so reset silences them at once.
    assign m0_cmd_ready = (state_q == ST_ISSUE) && cmd_ready && !grant_q;
    assign m1_cmd_ready = (state_q == ST_ISSUE) && cmd_ready &&  grant_q;
    assign m0_rsp_valid = rsp_fire && !grant_q;
    assign m1_rsp_valid = rsp_fire &&  grant_q;
    assign m0_rsp_data  = m0_rsp_valid ? rsp_payload : 8'h00;
    assign m1_rsp_data  = m1_rsp_valid ? rsp_payload : 8'h00;

endmodule

// File: tb/tb_dpu_pio_arbiter.sv
// Directed self-checking bench for dpu_pio_arbiter (RSP_TIMEOUT=8).
module tb_dpu_pio_arbiter;
    localparam int unsigned AW = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_cmd_valid, m0_cmd_ready, m0_rsp_valid;
    logic [2:0]    m0_cmd_type;
    logic [AW-1:0] m0_cmd_addr;
    logic [7:0]    m0_cmd_data, m0_rsp_data;
    logic          m1_cmd_valid, m1_cmd_ready, m1_rsp_valid, m1_lock;
    logic [2:0]    m1_cmd_type;
    logic [AW-1:0] m1_cmd_addr;
    logic [7:0]    m1_cmd_data, m1_rsp_data;
    logic          cmd_valid, cmd_ready, rsp_valid;
    logic [2:0]    cmd_type;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_data, rsp_data;
    logic          grant, busy, err_clr, stray_rsp, timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dpu_pio_arbiter #(.ADDR_BITS(AW), .RSP_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_type(m0_cmd_type),
        .m0_cmd_addr(m0_cmd_addr), .m0_cmd_data(m0_cmd_data),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_data(m0_rsp_data),
        .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_type(m1_cmd_type),
        .m1_cmd_addr(m1_cmd_addr), .m1_cmd_data(m1_cmd_data),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_data(m1_rsp_data), .m1_lock(m1_lock),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .grant(grant), .busy(busy), .err_clr(err_clr),
        .stray_rsp(stray_rsp), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive point: just after the rising edge. Check point: falling edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic wait_cmd(input string tag);
        int n = 0;
        do begin
            nxt();
            mid();
            n++;
        end while (!cmd_valid && n < 10);
        chk(tag, cmd_valid, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            nxt();
            mid();
            n++;
        end while (busy && n < 10);
        chk(tag, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        m0_cmd_valid = 0; m0_cmd_type = 0; m0_cmd_addr = 0; m0_cmd_data = 0;
        m1_cmd_valid = 0; m1_cmd_type = 0; m1_cmd_addr = 0; m1_cmd_data = 0;
        m1_lock = 0; cmd_ready = 0; rsp_valid = 0; rsp_data = 0; err_clr = 0;

        // Reset state
        repeat (2) mid();
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stray", stray_rsp, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_addr", cmd_addr, 0);
        rst_n = 1'b1;

        // Single write from m0
        nxt();
        m0_cmd_valid = 1; m0_cmd_type = 3'd0; m0_cmd_addr = 24'h000010; m0_cmd_data = 8'hA5;
        cmd_ready = 1;
        mid();
        chk("wr_no_valid_yet", cmd_valid, 0);
        chk("wr_no_ready_yet", m0_cmd_ready, 0);
        nxt(); mid();
        chk("wr_cmd_valid", cmd_valid, 1);
        chk("wr_cmd_addr", cmd_addr, 32'h10);
        chk("wr_cmd_data", cmd_data, 32'hA5);
        chk("wr_cmd_type", cmd_type, 0);
        chk("wr_grant", grant, 0);
        chk("wr_m0_ready", m0_cmd_ready, 1);
        chk("wr_m1_ready", m1_cmd_ready, 0);
        m0_cmd_valid = 0;
        nxt(); mid();
        chk("wr_hold_valid", cmd_valid, 0);
        chk("wr_hold_ready", m0_cmd_ready, 0);
        chk("wr_hold_busy", busy, 1);
        nxt(); mid();
        chk("wr_idle", busy, 0);

        // Read from m1, response after 5 cycles
        m1_cmd_valid = 1; m1_cmd_type = 3'd2; m1_cmd_addr = 24'h000100; m1_cmd_data = 8'h00;
        wait_cmd("rd_seen");
        chk("rd_grant", grant, 1);
        chk("rd_m1_ready", m1_cmd_ready, 1);
        chk("rd_m0_ready", m0_cmd_ready, 0);
        chk("rd_cmd_type", cmd_type, 2);
        m1_cmd_valid = 0;
        for (int c = 1; c <= 4; c++) begin
            nxt(); mid();
            chk("rd_wait_no_rsp", m1_rsp_valid, 0);
        end
        nxt();
        rsp_valid = 1; rsp_data = 8'h3C;
        mid();
        chk("rd_m1_rsp_valid", m1_rsp_valid, 1);
        chk("rd_m1_rsp_data", m1_rsp_data, 32'h3C);
        chk("rd_m0_rsp_valid", m0_rsp_valid, 0);
        chk("rd_m0_rsp_data", m0_rsp_data, 0);
        nxt();
        rsp_valid = 0; rsp_data = 0;
        mid();
        chk("rd_rsp_one_pulse", m1_rsp_valid, 0);
        chk("rd_no_stray", stray_rsp, 0);
        wait_idle("rd_idle");

        // Contention, last grant was m1: expect 0,1,0,1
        m0_cmd_valid = 1; m0_cmd_type = 3'd0; m0_cmd_addr = 24'h000111; m0_cmd_data = 8'h11;
        m1_cmd_valid = 1; m1_cmd_type = 3'd0; m1_cmd_addr = 24'h000222; m1_cmd_data = 8'h22;
        for (int i = 0; i < 4; i++) begin
            logic exp_g;
            exp_g = i[0];
            wait_cmd("rr_seen");
            chk("rr_grant", grant, exp_g);
            chk("rr_addr", cmd_addr, exp_g ? 32'h222 : 32'h111);
            chk("rr_m0_ready", m0_cmd_ready, !exp_g);
            chk("rr_m1_ready", m1_cmd_ready, exp_g);
        end
        // Locked DMA keeps the grant
        m1_lock = 1;
        for (int i = 0; i < 4; i++) begin
            wait_cmd("lock_seen");
            chk("lock_grant", grant, 1);
            chk("lock_m1_ready", m1_cmd_ready, 1);
        end
        m0_cmd_valid = 0; m1_cmd_valid = 0; m1_lock = 0;
        wait_idle("rr_idle");

        // Stray response while idle
        nxt();
        rsp_valid = 1; rsp_data = 8'h55;
        mid();
        chk("stray_m0_rsp", m0_rsp_valid, 0);
        chk("stray_m1_rsp", m1_rsp_valid, 0);
        chk("stray_m1_data", m1_rsp_data, 0);
        nxt();
        rsp_valid = 0;
        mid();
        chk("stray_set", stray_rsp, 1);
        nxt(); err_clr = 1;
        nxt(); err_clr = 0;
        mid();
        chk("stray_cleared", stray_rsp, 0);
        nxt(); err_clr = 1; rsp_valid = 1;
        nxt(); err_clr = 0; rsp_valid = 0;
        mid();
        chk("stray_set_wins", stray_rsp, 1);
        nxt(); err_clr = 1;
        nxt(); err_clr = 0;
        mid();
        chk("stray_cleared2", stray_rsp, 0);

        // Read from m0 with no response
        m0_cmd_valid = 1; m0_cmd_type = 3'd2; m0_cmd_addr = 24'h000020; m0_cmd_data = 8'h00;
        wait_cmd("to_seen");
        chk("to_grant", grant, 0);
        m0_cmd_valid = 0;
`ifdef DPU_PIO_ARB_TIMEOUT_EN
        for (int c = 1; c <= 7; c++) begin
            nxt(); mid();
            chk("to_early", m0_rsp_valid, 0);
        end
        nxt(); mid();
        chk("to_rsp_valid", m0_rsp_valid, 1);
        chk("to_rsp_data", m0_rsp_data, 0);
        chk("to_m1_rsp", m1_rsp_valid, 0);
        nxt(); mid();
        chk("to_err_set", timeout_err, 1);
        chk("to_one_pulse", m0_rsp_valid, 0);
        rsp_valid = 1; rsp_data = 8'h99;
        #1;
        chk("to_late_not_fwd", m0_rsp_valid, 0);
        nxt(); rsp_valid = 0;
        mid();
        chk("to_late_stray", stray_rsp, 1);
        nxt(); err_clr = 1;
        nxt(); err_clr = 0;
        mid();
        chk("to_err_cleared", timeout_err, 0);
        chk("to_stray_cleared", stray_rsp, 0);
`else
        for (int c = 1; c <= 20; c++) begin
            nxt(); mid();
        end
        chk("nto_busy", busy, 1);
        chk("nto_no_rsp", m0_rsp_valid, 0);
        chk("nto_err_zero", timeout_err, 0);
        nxt(); rsp_valid = 1; rsp_data = 8'h77;
        mid();
        chk("nto_rsp_valid", m0_rsp_valid, 1);
        chk("nto_rsp_data", m0_rsp_data, 32'h77);
        nxt(); rsp_valid = 0;
`endif
        wait_idle("to_idle");

        // Reset in the middle of WAIT_RSP
        m1_cmd_valid = 1; m1_cmd_type = 3'd2; m1_cmd_addr = 24'h000300;
        wait_cmd("mr_seen");
        m1_cmd_valid = 0;
        nxt(); mid();
        chk("mr_waiting", busy, 1);
        nxt();
        rst_n = 0;
        #1;
        chk("mr_cmd_valid", cmd_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_grant", grant, 0);
        rsp_valid = 1; rsp_data = 8'hEE;
        #1;
        chk("mr_no_rsp_in_rst", m1_rsp_valid, 0);
        rsp_valid = 0;
        mid();
        rst_n = 1;
        nxt(); mid();
        chk("mr_stray_clear", stray_rsp, 0);
        nxt(); rsp_valid = 1; rsp_data = 8'hEE;
        mid();
        chk("mr_late_m1", m1_rsp_valid, 0);
        chk("mr_late_m0", m0_rsp_valid, 0);
        nxt(); rsp_valid = 0;
        mid();
        chk("mr_late_stray", stray_rsp, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
